// File: rtl/mbox_pkg.sv
// Shared types for the AXI4 mailbox responder: AXI channel bundles, register offsets,
// FSM state enums and the STATUS word packer.
package mbox_pkg;

    localparam int AXI_ID_W = 4;

    localparam logic [1:0] MBOX_PUSH_OFF = 2'd0;
    localparam logic [1:0] MBOX_POP_OFF  = 2'd1;
    localparam logic [1:0] MBOX_STAT_OFF = 2'd2;
    localparam logic [1:0] MBOX_MASK_OFF = 2'd3;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} mbox_wr_st_t;
    typedef enum logic       {R_IDLE, R_DATA}         mbox_rd_st_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] awid;
        logic [31:0]         awaddr;
        logic [7:0]          awlen;
        logic [2:0]          awsize;
        logic [1:0]          awburst;
        logic                awvalid;
        logic [31:0]         wdata;
        logic [3:0]          wstrb;
        logic                wlast;
        logic                wvalid;
        logic                bready;
        logic [AXI_ID_W-1:0] arid;
        logic [31:0]         araddr;
        logic [7:0]          arlen;
        logic [2:0]          arsize;
        logic [1:0]          arburst;
        logic                arvalid;
        logic                rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                awready;
        logic                wready;
        logic [AXI_ID_W-1:0] bid;
        logic [1:0]          bresp;
        logic                bvalid;
        logic                arready;
        logic [AXI_ID_W-1:0] rid;
        logic [31:0]         rdata;
        logic [1:0]          rresp;
        logic                rlast;
        logic                rvalid;
    } s_axi_miso_t;

    function automatic logic [31:0] mbox_status(input logic [8:0] cnt, input logic empty,
                                                input logic full);
        return {14'd0, full, empty, 7'd0, cnt};
    endfunction

endpackage

// File: rtl/mbox_fifo.sv
// Synchronous FIFO with occupancy count and head-of-queue data; push when full and
// pop when empty are ignored. DEPTH must be a power of two so pointers wrap naturally.
module mbox_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_empty_nxt
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_head      = r_mem[r_rptr];
    assign o_count     = r_count;
    assign o_empty_nxt = (w_count_nxt == '0);

endmodule

// File: rtl/axi_mbox_slave.sv
// AXI4 mailbox responder: remote writes push into a receive FIFO, reads pop it or
// return STATUS. Define MBOX_IRQ_MASK_EN to add the MASK register at offset 0xC.
module axi_mbox_slave
    import mbox_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'hB000_0000
) (
    input  logic        clk_core,
    input  logic        arst_core,
    input  s_axi_mosi_t axi_mosi,
    output s_axi_miso_t axi_miso,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    mbox_wr_st_t         r_wst;
    mbox_wr_st_t         w_wst_nxt;
    mbox_rd_st_t         r_rdst;
    mbox_rd_st_t         w_rdst_nxt;
    logic                r_live;
    logic [AXI_ID_W-1:0] r_awid;
    logic [AXI_ID_W-1:0] r_arid;
    logic [1:0]          r_woff;
    logic [1:0]          r_roff;
    logic [7:0]          r_awlen;
    logic [7:0]          r_arlen;
    logic [7:0]          r_wbeat;
    logic [7:0]          r_rbeat;
    logic                r_werr;
    logic                r_rd_fresh;
    logic                r_irq;
    logic                w_mask_nxt;
    logic [31:0]         r_rdata;
    logic [31:0]         w_rdata_live;
    logic [31:0]         w_rdata_beat;
    logic [1:0]          r_rresp;
    logic [1:0]          w_rresp_live;
    logic [1:0]          w_rresp_beat;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_w_done;
    logic                w_b_hs;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_r_last;
    logic                w_push;
    logic                w_pop;
    logic                w_wdrop;
    logic                w_woff_bad;
    logic [31:0]         w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_empty_nxt;
    logic [CW-1:0]       w_count;
    logic                w_unused;
`ifdef MBOX_IRQ_MASK_EN
    logic                r_mask;
    logic                w_mask_wr;
`endif

    assign w_aw_hs  = (r_wst == W_IDLE) && r_live && axi_mosi.awvalid;
    assign w_w_hs   = (r_wst == W_DATA) && axi_mosi.wvalid;
    assign w_w_done = w_w_hs && (r_wbeat == r_awlen);
    assign w_b_hs   = (r_wst == W_RESP) && axi_mosi.bready;
    assign w_ar_hs  = (r_rdst == R_IDLE) && r_live && axi_mosi.arvalid;
    assign w_r_hs   = (r_rdst == R_DATA) && axi_mosi.rready;
    assign w_r_last = (r_rbeat == r_arlen);

`ifdef MBOX_IRQ_MASK_EN
    assign w_woff_bad = (r_woff == MBOX_POP_OFF) || (r_woff == MBOX_STAT_OFF);
    assign w_mask_wr  = w_w_hs && (r_woff == MBOX_MASK_OFF);
    assign w_mask_nxt = w_mask_wr ? axi_mosi.wdata[0] : r_mask;
`else
    assign w_woff_bad = (r_woff != MBOX_PUSH_OFF);
    assign w_mask_nxt = 1'b1;
`endif

    // Push/pop decisions are made against the occupancy at the start of the cycle.
    assign w_push  = w_w_hs && (r_woff == MBOX_PUSH_OFF);
    assign w_wdrop = w_w_hs && (w_woff_bad || ((r_woff == MBOX_PUSH_OFF) && w_full));
    assign w_pop   = w_r_hs && (r_roff == MBOX_POP_OFF) && (w_rresp_beat == AXI_OKAY);

    mbox_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .i_clk      (clk_core),
        .i_rst      (arst_core),
        .i_push     (w_push),
        .i_wdata    (axi_mosi.wdata),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_empty_nxt(w_empty_nxt)
    );

    always_ff @(posedge clk_core) begin
        if (arst_core) begin
            r_wst  <= W_IDLE;
            r_rdst <= R_IDLE;
        end else begin
            r_wst  <= w_wst_nxt;
            r_rdst <= w_rdst_nxt;
        end
    end

    always_comb begin
        w_wst_nxt = r_wst;
        case (r_wst)
            W_IDLE:  if (w_aw_hs)  w_wst_nxt = W_DATA;
            W_DATA:  if (w_w_done) w_wst_nxt = W_RESP;
            W_RESP:  if (w_b_hs)   w_wst_nxt = W_IDLE;
            default: w_wst_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rdst_nxt = r_rdst;
        case (r_rdst)
            R_IDLE:  if (w_ar_hs) w_rdst_nxt = R_DATA;
            R_DATA:  if (w_r_hs && w_r_last) w_rdst_nxt = R_IDLE;
            default: w_rdst_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_core) begin
        if (arst_core) begin
            r_live     <= 1'b0;
            r_wbeat    <= '0;
            r_werr     <= 1'b0;
            r_rbeat    <= '0;
            r_rd_fresh <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            r_rd_fresh <= w_ar_hs || (w_r_hs && !w_r_last);
            r_irq      <= !w_empty_nxt && w_mask_nxt;
            if (w_aw_hs) begin
                r_wbeat <= '0;
                r_werr  <= 1'b0;
            end else if (w_w_hs) begin
                r_wbeat <= r_wbeat + 8'd1;
                r_werr  <= r_werr | w_wdrop;
            end
            if (w_ar_hs) begin
                r_rbeat <= '0;
            end else if (w_r_hs) begin
                r_rbeat <= r_rbeat + 8'd1;
            end
        end
    end

`ifdef MBOX_IRQ_MASK_EN
    always_ff @(posedge clk_core) begin
        if (arst_core) r_mask <= 1'b1;
        else           r_mask <= w_mask_nxt;
    end
`endif

    always_ff @(posedge clk_core) begin
        if (w_aw_hs) begin
            r_awid  <= axi_mosi.awid;
            r_woff  <= axi_mosi.awaddr[3:2];
            r_awlen <= axi_mosi.awlen;
        end
        if (w_ar_hs) begin
            r_arid  <= axi_mosi.arid;
            r_roff  <= axi_mosi.araddr[3:2];
            r_arlen <= axi_mosi.arlen;
        end
        r_rdata <= w_rdata_beat;
        r_rresp <= w_rresp_beat;
    end

    always_comb begin
        w_rdata_live = '0;
        w_rresp_live = AXI_OKAY;
        case (r_roff)
            MBOX_POP_OFF: begin
                if (w_empty) w_rresp_live = AXI_SLVERR;
                else         w_rdata_live = w_head;
            end
            MBOX_STAT_OFF: w_rdata_live = mbox_status(9'(w_count), w_empty, w_full);
            MBOX_MASK_OFF: begin
`ifdef MBOX_IRQ_MASK_EN
                w_rdata_live = {31'd0, r_mask};
`endif
            end
            default: ;
        endcase
    end

    // Each beat's data is sampled when rvalid rises and then held until its handshake.
    assign w_rdata_beat = r_rd_fresh ? w_rdata_live : r_rdata;
    assign w_rresp_beat = r_rd_fresh ? w_rresp_live : r_rresp;

    always_comb begin
        axi_miso         = '0;
        axi_miso.awready = (r_wst == W_IDLE) && r_live;
        axi_miso.wready  = (r_wst == W_DATA);
        if (r_wst == W_RESP) begin
            axi_miso.bvalid = 1'b1;
            axi_miso.bid    = r_awid;
            axi_miso.bresp  = r_werr ? AXI_SLVERR : AXI_OKAY;
        end
        axi_miso.arready = (r_rdst == R_IDLE) && r_live;
        if (r_rdst == R_DATA) begin
            axi_miso.rvalid = 1'b1;
            axi_miso.rid    = r_arid;
            axi_miso.rdata  = w_rdata_beat;
            axi_miso.rresp  = w_rresp_beat;
            axi_miso.rlast  = w_r_last;
        end
    end

    assign irq_o = r_irq;

    assign w_unused = ^{BASE_ADDR, axi_mosi.awaddr[31:4], axi_mosi.awaddr[1:0], axi_mosi.awsize,
                        axi_mosi.awburst, axi_mosi.wstrb, axi_mosi.wlast, axi_mosi.araddr[31:4],
                        axi_mosi.araddr[1:0], axi_mosi.arsize, axi_mosi.arburst};

endmodule

// File: tb/tb_axi_mbox_slave.sv
// Directed bench for axi_mbox_slave (FIFO_DEPTH=8); MBOX_IRQ_MASK_EN selects the mask steps.
module tb_axi_mbox_slave;
    import mbox_pkg::*;

    localparam logic [31:0] BASE = 32'hB000_0000;

    logic        clk = 1'b0;
    logic        arst_core;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;
    logic        irq;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [1:0]  resp;
    logic [31:0] data;
    logic        last;
    logic [3:0]  rid;

    axi_mbox_slave #(
        .FIFO_DEPTH(8),
        .BASE_ADDR (32'hB000_0000)
    ) dut (
        .clk_core (clk),
        .arst_core(arst_core),
        .axi_mosi (mosi),
        .axi_miso (miso),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [1:0] off, input logic [7:0] len, input logic [3:0] id);
        int n = 0;
        mosi.awid    = id;
        mosi.awaddr  = BASE | {28'd0, off, 2'b00};
        mosi.awlen   = len;
        mosi.awsize  = 3'd2;
        mosi.awburst = 2'b01;
        mosi.awvalid = 1'b1;
        @(negedge clk);
        while (!miso.awready && n < 50) begin @(negedge clk); n++; end
        check("aw_handshake", {31'd0, miso.awready}, 32'd1);
        sync();
        mosi.awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [1:0] off, input logic [7:0] len, input logic [3:0] id);
        int n = 0;
        mosi.arid    = id;
        mosi.araddr  = BASE | {28'd0, off, 2'b00};
        mosi.arlen   = len;
        mosi.arsize  = 3'd2;
        mosi.arburst = 2'b01;
        mosi.arvalid = 1'b1;
        @(negedge clk);
        while (!miso.arready && n < 50) begin @(negedge clk); n++; end
        check("ar_handshake", {31'd0, miso.arready}, 32'd1);
        sync();
        mosi.arvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic l);
        int n = 0;
        mosi.wdata  = d;
        mosi.wstrb  = 4'hF;
        mosi.wlast  = l;
        mosi.wvalid = 1'b1;
        @(negedge clk);
        while (!miso.wready && n < 50) begin @(negedge clk); n++; end
        check("w_handshake", {31'd0, miso.wready}, 32'd1);
        sync();
        mosi.wvalid = 1'b0;
    endtask

    task automatic b_recv(input logic [3:0] exp_id, output logic [1:0] r);
        int n = 0;
        mosi.bready = 1'b1;
        @(negedge clk);
        while (!miso.bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_handshake", {31'd0, miso.bvalid}, 32'd1);
        check("bid", {28'd0, miso.bid}, {28'd0, exp_id});
        r = miso.bresp;
        sync();
        mosi.bready = 1'b0;
    endtask

    task automatic r_recv(output logic [31:0] d, output logic [1:0] r, output logic l,
                          output logic [3:0] id);
        int n = 0;
        mosi.rready = 1'b1;
        @(negedge clk);
        while (!miso.rvalid && n < 50) begin @(negedge clk); n++; end
        check("r_handshake", {31'd0, miso.rvalid}, 32'd1);
        d  = miso.rdata;
        r  = miso.rresp;
        l  = miso.rlast;
        id = miso.rid;
        sync();
        mosi.rready = 1'b0;
    endtask

    task automatic wr1(input logic [1:0] off, input logic [31:0] d, input logic [3:0] id,
                       output logic [1:0] r);
        aw_send(off, 8'd0, id);
        w_send(d, 1'b1);
        b_recv(id, r);
    endtask

    task automatic rd1(input logic [1:0] off, input logic [3:0] id, output logic [31:0] d,
                       output logic [1:0] r);
        logic       l;
        logic [3:0] i;
        ar_send(off, 8'd0, id);
        r_recv(d, r, l, i);
        check("rd1_rlast", {31'd0, l}, 32'd1);
        check("rd1_rid", {28'd0, i}, {28'd0, id});
    endtask

    initial begin
        mosi      = '0;
        arst_core = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_miso_zero", {31'd0, (miso == '0)}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        sync();
        arst_core = 1'b0;
        sync();
        @(negedge clk);
        check("idle_awready", {31'd0, miso.awready}, 32'd1);
        check("idle_arready", {31'd0, miso.arready}, 32'd1);
        sync();

        // Single push of DEADBEEF, irq one cycle after the push
        aw_send(MBOX_PUSH_OFF, 8'd0, 4'h5);
        @(negedge clk);
        check("irq_before_push", {31'd0, irq}, 32'd0);
        sync();
        w_send(32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        check("irq_after_push", {31'd0, irq}, 32'd1);
        sync();
        b_recv(4'h5, resp);
        check("push1_bresp", {30'd0, resp}, {30'd0, AXI_OKAY});
        rd1(MBOX_STAT_OFF, 4'h3, data, resp);
        check("status_cnt1", data, 32'h0000_0001);
        check("status_cnt1_resp", {30'd0, resp}, {30'd0, AXI_OKAY});
        rd1(MBOX_POP_OFF, 4'h3, data, resp);
        check("pop_deadbeef", data, 32'hDEAD_BEEF);
        @(negedge clk);
        check("irq_after_drain", {31'd0, irq}, 32'd0);
        sync();

        // INCR burst push of 1..4 then burst pop
        aw_send(MBOX_PUSH_OFF, 8'd3, 4'h7);
        for (int i = 0; i < 4; i++) w_send(32'(i + 1), 1'(i == 3));
        b_recv(4'h7, resp);
        check("burst_bresp", {30'd0, resp}, {30'd0, AXI_OKAY});
        ar_send(MBOX_POP_OFF, 8'd3, 4'h9);
        for (int i = 0; i < 4; i++) begin
            r_recv(data, resp, last, rid);
            check("burst_rdata", data, 32'(i + 1));
            check("burst_rlast", {31'd0, last}, {31'd0, 1'(i == 3)});
            check("burst_rresp", {30'd0, resp}, {30'd0, AXI_OKAY});
        end
        @(negedge clk);
        check("burst_irq_low", {31'd0, irq}, 32'd0);
        sync();
        rd1(MBOX_STAT_OFF, 4'h1, data, resp);
        check("status_empty", data, 32'h0001_0000);

        // Overfill: nine pushes into an eight-entry FIFO
        for (int i = 0; i < 9; i++) begin
            wr1(MBOX_PUSH_OFF, 32'h100 + 32'(i), 4'(i), resp);
            check("fill_bresp", {30'd0, resp}, (i < 8) ? {30'd0, AXI_OKAY} : {30'd0, AXI_SLVERR});
        end
        rd1(MBOX_STAT_OFF, 4'h2, data, resp);
        check("status_full", data, 32'h0002_0008);

        // Concurrent pop and push while full
        mosi.awid    = 4'hA;
        mosi.awaddr  = BASE | 32'h0;
        mosi.awlen   = 8'd0;
        mosi.awvalid = 1'b1;
        mosi.arid    = 4'hB;
        mosi.araddr  = BASE | 32'h4;
        mosi.arlen   = 8'd0;
        mosi.arvalid = 1'b1;
        mosi.wdata   = 32'hCAFE_F00D;
        mosi.wlast   = 1'b1;
        mosi.wvalid  = 1'b1;
        mosi.rready  = 1'b1;
        @(negedge clk);
        check("conc_aw_ar_ready", {30'd0, miso.awready, miso.arready}, 32'd3);
        sync();
        mosi.awvalid = 1'b0;
        mosi.arvalid = 1'b0;
        @(negedge clk);
        check("conc_same_cycle", {30'd0, miso.wready, miso.rvalid}, 32'd3);
        data = miso.rdata;
        resp = miso.rresp;
        sync();
        mosi.wvalid = 1'b0;
        mosi.rready = 1'b0;
        check("conc_pop_data", data, 32'h0000_0100);
        check("conc_pop_resp", {30'd0, resp}, {30'd0, AXI_OKAY});
        b_recv(4'hA, resp);
        check("conc_push_bresp", {30'd0, resp}, {30'd0, AXI_SLVERR});
        rd1(MBOX_STAT_OFF, 4'h2, data, resp);
        check("conc_status_cnt7", data, 32'h0000_0007);

        // Drain the remaining seven entries
        ar_send(MBOX_POP_OFF, 8'd6, 4'hC);
        for (int i = 0; i < 7; i++) begin
            r_recv(data, resp, last, rid);
            check("drain_rdata", data, 32'h101 + 32'(i));
            check("drain_rlast", {31'd0, last}, {31'd0, 1'(i == 6)});
        end
        check("drain_rid", {28'd0, rid}, 32'h0000_000C);

        // Pop from empty FIFO
        rd1(MBOX_POP_OFF, 4'h4, data, resp);
        check("empty_pop_data", data, 32'd0);
        check("empty_pop_resp", {30'd0, resp}, {30'd0, AXI_SLVERR});
        rd1(MBOX_STAT_OFF, 4'h4, data, resp);
        check("empty_pop_status", data, 32'h0001_0000);

        // Illegal accesses
        rd1(MBOX_PUSH_OFF, 4'h6, data, resp);
        check("rd_push_data", data, 32'd0);
        check("rd_push_resp", {30'd0, resp}, {30'd0, AXI_OKAY});
        wr1(MBOX_POP_OFF, 32'h1234, 4'h6, resp);
        check("wr_pop_resp", {30'd0, resp}, {30'd0, AXI_SLVERR});
        wr1(MBOX_STAT_OFF, 32'h1234, 4'h6, resp);
        check("wr_stat_resp", {30'd0, resp}, {30'd0, AXI_SLVERR});
        rd1(MBOX_STAT_OFF, 4'h6, data, resp);
        check("illegal_wr_no_push", data, 32'h0001_0000);

`ifdef MBOX_IRQ_MASK_EN
        wr1(MBOX_MASK_OFF, 32'hFFFF_FFFE, 4'h8, resp);
        check("mask0_bresp", {30'd0, resp}, {30'd0, AXI_OKAY});
        wr1(MBOX_PUSH_OFF, 32'h55, 4'h8, resp);
        @(negedge clk);
        check("masked_irq", {31'd0, irq}, 32'd0);
        sync();
        aw_send(MBOX_MASK_OFF, 8'd0, 4'h8);
        w_send(32'h1, 1'b1);
        @(negedge clk);
        check("unmasked_irq", {31'd0, irq}, 32'd1);
        sync();
        b_recv(4'h8, resp);
        check("mask1_bresp", {30'd0, resp}, {30'd0, AXI_OKAY});
        rd1(MBOX_MASK_OFF, 4'h8, data, resp);
        check("mask_readback", data, 32'd1);
        rd1(MBOX_POP_OFF, 4'h8, data, resp);
        check("mask_pop", data, 32'h55);
`else
        rd1(MBOX_MASK_OFF, 4'h8, data, resp);
        check("rsvd_rd_data", data, 32'd0);
        check("rsvd_rd_resp", {30'd0, resp}, {30'd0, AXI_OKAY});
        wr1(MBOX_MASK_OFF, 32'h1, 4'h8, resp);
        check("rsvd_wr_resp", {30'd0, resp}, {30'd0, AXI_SLVERR});
`endif

        // Reset in the middle of a four-beat burst
        wr1(MBOX_PUSH_OFF, 32'h77, 4'h2, resp);
        aw_send(MBOX_PUSH_OFF, 8'd3, 4'h2);
        w_send(32'hA, 1'b0);
        w_send(32'hB, 1'b0);
        @(negedge clk);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        sync();
        arst_core = 1'b1;
        sync();
        arst_core = 1'b0;
        @(negedge clk);
        check("midrst_miso_zero", {31'd0, (miso == '0)}, 32'd1);
        sync();
        @(negedge clk);
        check("midrst_awready", {31'd0, miso.awready}, 32'd1);
        check("midrst_bvalid", {31'd0, miso.bvalid}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        sync();
        rd1(MBOX_STAT_OFF, 4'h1, data, resp);
        check("midrst_status", data, 32'h0001_0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
